w0rm_alu_issue: RTL

- Issue/collect controller that drives one W0RM ALU functional unit, such as the shift or logic units.
- Accepts an operation request over a valid/ready handshake and presents it to the unit as a one-cycle `data_valid` strobe with opcode and operands.
- Waits for the unit's `result_valid`, which may arrive in the same cycle (SINGLE_CYCLE units) or many cycles later.
- Holds result and flags on a valid/ready writeback port until the register file accepts them.

---
 rtl/w0rm_alu_issue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/w0rm_alu_issue.sv
// w0rm_alu_issue: issue/collect controller for one W0RM ALU functional unit.
// A request is accepted over valid/ready and issued to the unit as a one-cycle
// strobe. The controller then waits, with a bounded timeout, for the unit's
// result and holds result and flags on a valid/ready writeback port.
module w0rm_alu_issue #(
   parameter int DATA_WIDTH     = 8,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   // request port
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [3:0]                req_opcode,
   input  logic [DATA_WIDTH-1:0]     req_a,
   input  logic [DATA_WIDTH-1:0]     req_b,
   input  logic [REG_ADDR_WIDTH-1:0] req_dest,
   // functional unit port
   output logic                      alu_data_valid,
   output logic [3:0]                alu_opcode,
   output logic [DATA_WIDTH-1:0]     alu_data_a,
   output logic [DATA_WIDTH-1:0]     alu_data_b,
   input  logic [DATA_WIDTH-1:0]     alu_result,
   input  logic                      alu_result_valid,
   input  logic [3:0]                alu_result_flags,
   // writeback port
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [REG_ADDR_WIDTH-1:0] wb_dest,
   output logic [DATA_WIDTH-1:0]     wb_result,
   output logic [3:0]                wb_flags,
   output logic                      wb_timeout,
   output logic                      busy
);

   // One extra bit so the terminal count is always representable.
   localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [CNT_WIDTH-1:0] wait_cnt;

   logic accept;       // request handshake completes this cycle
   logic capture;      // unit result is taken this cycle
   logic timeout_hit;  // last WAIT cycle expired with no result

   assign accept      = req_valid & req_ready;
   assign capture     = ((state == ST_ISSUE) || (state == ST_WAIT)) & alu_result_valid;
   // A result on the final WAIT cycle takes priority over the timeout.
   assign timeout_hit = (state == ST_WAIT) & ~alu_result_valid & (wait_cnt == CNT_LAST);

   // State register; reset returns to IDLE at once, dropping every strobe.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // next_state unassigned, which would infer a latch.
      next_state = state;
      case (state)
         ST_IDLE:  if (req_valid) next_state = ST_ISSUE;
         ST_ISSUE: next_state = alu_result_valid ? ST_WB : ST_WAIT;
         ST_WAIT:  if (alu_result_valid || (wait_cnt == CNT_LAST)) next_state = ST_WB;
         ST_WB:    if (wb_ready) next_state = req_valid ? ST_ISSUE : ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Output decode; strobes come straight from state so reset clears them
   // without waiting for a clock edge. req_ready never looks at req_valid.
   always_comb begin
      req_ready      = (state == ST_IDLE) || ((state == ST_WB) && wb_ready);
      alu_data_valid = (state == ST_ISSUE);
      wb_valid       = (state == ST_WB);
      busy           = (state != ST_IDLE);
   end

   // Datapath: latch the request, run the wait counter, capture the result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_opcode <= '0;
         alu_data_a <= '0;
         alu_data_b <= '0;
         wb_dest    <= '0;
         wb_result  <= '0;
         wb_flags   <= '0;
         wb_timeout <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         // Operands stay put from issue until the next accepted request.
         if (accept) begin
            alu_opcode <= req_opcode;
            alu_data_a <= req_a;
            alu_data_b <= req_b;
            wb_dest    <= req_dest;
         end

         // Counter restarts on every issue and saturates at the terminal count.
         if (state == ST_ISSUE) begin
            wait_cnt <= '0;
         end else if ((state == ST_WAIT) && (wait_cnt != CNT_LAST)) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
         end

         // Results are only taken while an op is outstanding, so a late
         // result after a timeout falls into IDLE/WB and is dropped.
         if (capture) begin
            wb_result  <= alu_result;
            wb_flags   <= alu_result_flags;
            wb_timeout <= 1'b0;
         end else if (timeout_hit) begin
            wb_result  <= '0;
            wb_flags   <= '0;
            wb_timeout <= 1'b1;
         end
      end
   end

endmodule
